// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, I-mem request, fetch queue and DE latch.
// Optional fetch-time JAL prediction is built when FETCH_PREDICT_JAL_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IM_REQ,
    output logic [31:0] IM_ADDR,
    input  logic [31:0] IM_DATA,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] DE_PC,
    output logic [31:0] DE_IR,
    output logic        DE_V,
    output logic        DE_PRED,
    output logic        HALTED
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [XLEN-1:0]  INSN_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0]  INSN_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0]  INSN_EBREAK = 32'h0010_0073;
    localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(QDEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic            pred;
    } fq_entry_t;

    logic [XLEN-1:0]  fpc_q, fpc_d;
    logic             infl_v_q, infl_v_d;
    logic [XLEN-1:0]  infl_pc_q, infl_pc_d;
    logic             infl_kill_q, infl_kill_d;
    fq_entry_t        fq_q [QDEPTH];
    fq_entry_t        fq_d [QDEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  de_pc_q, de_pc_d;
    logic [XLEN-1:0]  de_ir_q, de_ir_d;
    logic             de_v_q, de_v_d;
    logic             de_pred_q, de_pred_d;
    logic             halted_q, halted_d;

    logic             im_req_c;
    logic             live_c;
    logic             sys_c;
    logic             pred_c;
    logic             push_c;
    logic             pop_c;
    fq_entry_t        resp_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FETCH_PREDICT_JAL_EN
    localparam logic [6:0] OPC_JAL = 7'b110_1111;
    logic [XLEN-1:0] jal_tgt_c;

    assign jal_tgt_c = infl_pc_q + {{12{IM_DATA[31]}}, IM_DATA[19:12], IM_DATA[20],
                                    IM_DATA[30:21], 1'b0};
`endif

    // Occupancy counts the in-flight word so a response can always be queued.
    assign im_req_c = !RST && !halted_q && !REDIRECT &&
                      ((SUM_W'(count_q) + SUM_W'(infl_v_q)) < SUM_W'(QDEPTH));

    always_comb begin
        live_c = infl_v_q && !infl_kill_q;
        sys_c  = live_c && ((IM_DATA == INSN_ECALL) || (IM_DATA == INSN_EBREAK));
`ifdef FETCH_PREDICT_JAL_EN
        pred_c = live_c && (IM_DATA[6:0] == OPC_JAL);
`else
        pred_c = 1'b0;
`endif
        resp_c.pc   = infl_pc_q;
        resp_c.ir   = IM_DATA;
        resp_c.pred = pred_c;
    end

    always_comb begin
        fpc_d       = fpc_q;
        infl_v_d    = 1'b0;
        infl_pc_d   = infl_pc_q;
        infl_kill_d = 1'b0;
        fq_d        = fq_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        de_pc_d     = de_pc_q;
        de_ir_d     = de_ir_q;
        de_v_d      = de_v_q;
        de_pred_d   = de_pred_q;
        halted_d    = halted_q;
        pop_c       = !STALL && (count_q != '0);
        push_c      = live_c && (STALL || (count_q != '0));

        // A request racing a halt or a predicted JAL is on the wrong path.
        if (im_req_c) begin
            infl_v_d    = 1'b1;
            infl_pc_d   = fpc_q;
            infl_kill_d = sys_c || pred_c;
            fpc_d       = fpc_q + XLEN'(4);
        end
`ifdef FETCH_PREDICT_JAL_EN
        if (pred_c) begin
            fpc_d = jal_tgt_c;
        end
`endif
        if (sys_c) begin
            halted_d = 1'b1;
        end

        if (!STALL) begin
            if (pop_c) begin
                de_pc_d   = fq_q[head_q].pc;
                de_ir_d   = fq_q[head_q].ir;
                de_pred_d = fq_q[head_q].pred;
                de_v_d    = 1'b1;
            end else if (live_c) begin
                de_pc_d   = resp_c.pc;
                de_ir_d   = resp_c.ir;
                de_pred_d = resp_c.pred;
                de_v_d    = 1'b1;
            end else begin
                de_v_d    = 1'b0;
            end
        end

        if (push_c) begin
            fq_d[tail_q] = resp_c;
            tail_d       = ptr_inc(tail_q);
        end
        if (pop_c) begin
            head_d = ptr_inc(head_q);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Redirect discards everything younger than the redirecting instruction.
        if (REDIRECT) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            infl_v_d    = 1'b0;
            infl_kill_d = 1'b0;
            de_v_d      = 1'b0;
            de_pred_d   = 1'b0;
            fpc_d       = REDIRECT_PC;
            halted_d    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fpc_q       <= RESET_PC;
            infl_v_q    <= 1'b0;
            infl_pc_q   <= '0;
            infl_kill_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            de_pc_q     <= '0;
            de_ir_q     <= INSN_NOP;
            de_v_q      <= 1'b0;
            de_pred_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            fpc_q       <= fpc_d;
            infl_v_q    <= infl_v_d;
            infl_pc_q   <= infl_pc_d;
            infl_kill_q <= infl_kill_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            de_pc_q     <= de_pc_d;
            de_ir_q     <= de_ir_d;
            de_v_q      <= de_v_d;
            de_pred_q   <= de_pred_d;
            halted_q    <= halted_d;
        end
    end

    // Queue payload needs no reset; occupancy is tracked by count/head/tail.
    always_ff @(posedge CLK) begin
        fq_q <= fq_d;
    end

    assign IM_REQ  = im_req_c;
    assign IM_ADDR = fpc_q;
    assign DE_PC   = de_pc_q;
    assign DE_IR   = de_ir_q;
    assign DE_V    = de_v_q;
    assign DE_PRED = de_pred_q;
    assign HALTED  = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing checks plus random stall/redirect/reset traffic
// checked against a program-order model of the delivered instruction stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned QDEPTH   = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam logic [31:0] JAL16    = 32'h0100_006F;
`ifdef FETCH_PREDICT_JAL_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        IM_REQ;
    logic [31:0] IM_ADDR;
    logic [31:0] IM_DATA;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] DE_PC;
    logic [31:0] DE_IR;
    logic        DE_V;
    logic        DE_PRED;
    logic        HALTED;

    fetch_stage #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .CLK(CLK), .RST(RST), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_DATA(IM_DATA),
        .STALL(STALL), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .DE_PC(DE_PC), .DE_IR(DE_IR), .DE_V(DE_V), .DE_PRED(DE_PRED), .HALTED(HALTED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;
    logic [31:0] ovr_addr [8];
    logic [31:0] ovr_data [8];
    int          n_ovr    = 0;
    logic [31:0] mem_rd   = 32'h0;

    logic [31:0] exp_pc   = RESET_PC;
    bit          m_halted = 1'b0;
    logic [31:0] prev_pc, prev_ir;
    logic        prev_v, prev_pred;
    logic        req_s;
    logic [31:0] addr_s;

    // Program image: unique non-control word per address, plus overrides.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[26:2], 7'b0010011};
        for (int i = 0; i < 8; i++)
            if (i < n_ovr && ovr_addr[i] == a) w = ovr_data[i];
        return w;
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic bit is_jal(input logic [31:0] w);
        return w[6:0] == 7'b1101111;
    endfunction

    always @(posedge CLK) if (IM_REQ) mem_rd <= mem_word(IM_ADDR);
    assign IM_DATA = mem_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input bit rst, input bit stall, input bit redir,
                               input logic [31:0] rpc);
        logic [31:0] w;
        if (rst) begin
            chk("rst_de_v", 32'(DE_V), 32'd0);
            chk("rst_de_pc", DE_PC, 32'd0);
            chk("rst_de_ir", DE_IR, NOP);
            chk("rst_de_pred", 32'(DE_PRED), 32'd0);
            chk("rst_halted", 32'(HALTED), 32'd0);
            exp_pc   = RESET_PC;
            m_halted = 1'b0;
        end else if (redir) begin
            chk("redir_de_v", 32'(DE_V), 32'd0);
            chk("redir_de_pred", 32'(DE_PRED), 32'd0);
            chk("redir_halted", 32'(HALTED), 32'd0);
            exp_pc   = rpc;
            m_halted = 1'b0;
        end else if (stall) begin
            chk("hold_v", 32'(DE_V), 32'(prev_v));
            chk("hold_pc", DE_PC, prev_pc);
            chk("hold_ir", DE_IR, prev_ir);
            chk("hold_pred", 32'(DE_PRED), 32'(prev_pred));
        end else if (m_halted) begin
            chk("post_halt_v", 32'(DE_V), 32'd0);
        end else if (DE_V) begin
            w = mem_word(exp_pc);
            chk("deliv_pc", DE_PC, exp_pc);
            chk("deliv_ir", DE_IR, w);
            chk("deliv_pred", 32'(DE_PRED), 32'(PRED_EN && is_jal(w)));
            n_deliv++;
            if (w == ECALL || w == EBREAK) m_halted = 1'b1;
            exp_pc = (PRED_EN && is_jal(w)) ? exp_pc + jimm(w) : exp_pc + 32'd4;
        end
        if (m_halted) chk("halted_flag", 32'(HALTED), 32'd1);
        prev_v    = DE_V;
        prev_pc   = DE_PC;
        prev_ir   = DE_IR;
        prev_pred = DE_PRED;
    endtask

    task automatic cycle(input bit rst, input bit stall, input bit redir, input logic [31:0] rpc);
        RST         = rst;
        STALL       = stall;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        #1;
        req_s  = IM_REQ;
        addr_s = IM_ADDR;
        if (rst || redir || m_halted) chk("req_blocked", 32'(IM_REQ), 32'd0);
        @(posedge CLK);
        #1;
        check_cycle(rst, stall, redir, rpc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          d0;
        bit          r_rst, r_stall, r_redir;
        logic [31:0] r_tgt;

        RST = 1'b1; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0;
        prev_v = 1'b0; prev_pc = 32'h0; prev_ir = NOP; prev_pred = 1'b0;
        @(posedge CLK);
        #1;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Straight line after reset release
        d0 = n_deliv;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            chk("sl_req", 32'(req_s), 32'd1);
            chk("sl_addr", addr_s, RESET_PC + 32'(4 * k));
            if (k == 0) chk("sl_v_first_edge", 32'(DE_V), 32'd0);
            if (k == 1) begin
                chk("sl_v_second_edge", 32'(DE_V), 32'd1);
                chk("sl_pc_second_edge", DE_PC, RESET_PC);
            end
        end
        chk("throughput", 32'(n_deliv - d0), 32'd7);

        // Stall for three cycles
        cycle(1'b0, 1'b1, 1'b0, 32'h0); chk("st_req1", 32'(req_s), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0); chk("st_req2", 32'(req_s), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0); chk("st_req3", 32'(req_s), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0); chk("st_req4", 32'(req_s), 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect with a full queue, together with stall
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 32'h100);
        chk("rd_req_r", 32'(req_s), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_req_r1", 32'(req_s), 32'd1);
        chk("rd_addr_r1", addr_s, 32'h100);
        chk("rd_v_r1", 32'(DE_V), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_pc_r2", DE_PC, 32'h100);
        chk("rd_v_r2", 32'(DE_V), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rd_pc_r3", DE_PC, 32'h104);

        // Halt on ECALL at PC 8
        ovr_addr[0] = 32'h8; ovr_data[0] = ECALL; n_ovr = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("halt_pc", DE_PC, 32'h8);
        chk("halt_ir", DE_IR, 32'h73);
        chk("halt_flag", 32'(HALTED), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            chk("halt_req_idle", 32'(req_s), 32'd0);
            chk("halt_v_idle", 32'(DE_V), 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b1, 32'h200);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("restart_req", 32'(req_s), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("restart_pc", DE_PC, 32'h200);

        // JAL x0, +16 at PC 4
        ovr_addr[0] = 32'h4; ovr_data[0] = JAL16; n_ovr = 1;
        cycle(1'b0, 1'b0, 1'b1, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("jal_pc", DE_PC, 32'h4);
        chk("jal_pred", 32'(DE_PRED), 32'(PRED_EN));
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("jal_next_v", 32'(DE_V), PRED_EN ? 32'd0 : 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("jal_after_pc", DE_PC, PRED_EN ? 32'h14 : 32'hC);

        // Address wrap
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 1'b0, 32'h0); chk("wrap_a0", addr_s, 32'hFFFF_FFF8);
        cycle(1'b0, 1'b0, 1'b0, 32'h0); chk("wrap_a1", addr_s, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0); chk("wrap_a2", addr_s, 32'h0);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset during stall with a full queue, also overriding a redirect
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h300);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_req", 32'(req_s), 32'd1);
        chk("rst_mid_addr", addr_s, RESET_PC);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic against the program-order model
        ovr_addr[0] = 32'h48;  ovr_data[0] = ECALL;
        ovr_addr[1] = 32'h10C; ovr_data[1] = EBREAK;
        ovr_addr[2] = 32'h104; ovr_data[2] = JAL16;
        n_ovr = 3;
        d0 = n_deliv;
        for (int i = 0; i < 600; i++) begin
            r_rst   = ($urandom_range(0, 199) == 0);
            r_stall = ($urandom_range(0, 99) < 30);
            r_redir = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 4))
                0:       r_tgt = 32'h0;
                1:       r_tgt = 32'h40;
                2:       r_tgt = 32'h100;
                3:       r_tgt = 32'hFFFF_FFF0;
                default: r_tgt = $urandom() & 32'h0000_0FFC;
            endcase
            cycle(r_rst, r_stall, r_redir, r_tgt);
        end
        chk("rand_progress", 32'(n_deliv - d0 >= 60), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
